// File: rtl/fir3_pkg.sv
// fir3_pkg
// Items shared by the three-parallel FIR input feeder, the output serializer and the bench.
//   N_PHASE   : number of polyphase outputs per block.
//   lane_t    : index of one phase within a block.
//   LANE_LAST : index of the final phase of a block.
package fir3_pkg;

   localparam int N_PHASE = 3;

   typedef logic [1:0] lane_t;

   localparam lane_t LANE_LAST = lane_t'(N_PHASE - 1);

endpackage

// File: rtl/fir3_round_sat.sv
// fir3_round_sat
// Combinational round-half-up, arithmetic right shift and clamp to OUT_W bits.
// Ports:
//   x   in  IN_W  : two's-complement input sample
//   y   out OUT_W : rounded, shifted, saturated sample
//   sat out 1     : the clamp changed the value
module fir3_round_sat #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15
) (
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   // Half of one output LSB. With SHIFT=0 the shift-up-then-down leaves 0.
   localparam logic [IN_W:0] RND = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;
   localparam logic signed [IN_W:0] MAX_V = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] MIN_V = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   // One extra bit so the rounding add cannot wrap at the positive extreme.
   logic signed [IN_W:0] sum;
   logic signed [IN_W:0] shr;

   always_comb begin
      sum = $signed({x[IN_W-1], x}) + $signed(RND);
      shr = sum >>> SHIFT;
      sat = 1'b0;
      y   = shr[OUT_W-1:0];
      if (shr > MAX_V) begin
         sat = 1'b1;
         y   = MAX_V[OUT_W-1:0];
      end else if (shr < MIN_V) begin
         sat = 1'b1;
         y   = MIN_V[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/fir3_out_serializer.sv
// fir3_out_serializer
// Buffers up to DEPTH blocks of three FIR phase results and replays them as one
// serial stream in phase order 0,1,2, rounding and saturating each sample.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : block handshake; in_ready depends on registered state only
//   in_phase0..2 [IN_W]        : phase results for samples 3k, 3k+1, 3k+2
//   out_valid/out_ready        : serial sample handshake
//   out_data [OUT_W]           : rounded, saturated sample (0 when idle)
//   out_last                   : out_data is phase 2 of its block
//   clr_sat                    : synchronous clear of sat_flag, wins over a same-cycle set
//   sat_flag                   : sticky, an accepted sample was clamped
module fir3_out_serializer #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_phase0,
   input  logic [IN_W-1:0]  in_phase1,
   input  logic [IN_W-1:0]  in_phase2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   input  logic             clr_sat,
   output logic             sat_flag
);

   import fir3_pkg::*;

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [IN_W-1:0]  blk_buf [DEPTH][N_PHASE];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   lane_t            lane;

   logic             push;
   logic             pop;
   logic             pop_last;
   logic [IN_W-1:0]  cur;
   logic [OUT_W-1:0] rs_y;
   logic             rs_sat;

   // Modulo-DEPTH increment; with DEPTH=1 the pointer simply stays at 0.
   function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign pop_last  = pop && (lane == LANE_LAST);

   always_comb begin
      cur = blk_buf[rd_ptr][0];
      case (lane)
         2'd1:    cur = blk_buf[rd_ptr][1];
         2'd2:    cur = blk_buf[rd_ptr][2];
         default: cur = blk_buf[rd_ptr][0];
      endcase
   end

   fir3_round_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .x   (cur),
      .y   (rs_y),
      .sat (rs_sat)
   );

   assign out_data = out_valid ? rs_y : '0;
   assign out_last = out_valid && (lane == LANE_LAST);

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (push) begin
         blk_buf[wr_ptr][0] <= in_phase0;
         blk_buf[wr_ptr][1] <= in_phase1;
         blk_buf[wr_ptr][2] <= in_phase2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         lane     <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= nxt_ptr(wr_ptr);
         if (pop_last) begin
            lane   <= '0;
            rd_ptr <= nxt_ptr(rd_ptr);
         end else if (pop) begin
            lane   <= lane + lane_t'(1);
         end
         // A push paired with a final-lane pop leaves the occupancy unchanged.
         case ({push, pop_last})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (clr_sat)
            sat_flag <= 1'b0;
         else if (pop && rs_sat)
            sat_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir3_out_serializer.sv
// tb_fir3_out_serializer
// Scoreboarded bench: expected samples are queued when a block is accepted and
// popped when the serializer hands a sample to the sink.
module tb_fir3_out_serializer;

   import fir3_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_phase0 = '0;
   logic [63:0] in_phase1 = '0;
   logic [63:0] in_phase2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic        clr_sat = 1'b0;
   logic        sat_flag;

   fir3_out_serializer #(.IN_W(64), .OUT_W(16), .SHIFT(15), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_phase0 (in_phase0),
      .in_phase1 (in_phase1),
      .in_phase2 (in_phase2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .clr_sat   (clr_sat),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        last;
   } exp_t;

   typedef struct {
      logic [63:0] p0, p1, p2;
      logic [15:0] e0, e1, e2;
      logic        s;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   stall_cnt = 0;
   int   gaps = 0;
   bit   gap_chk = 1'b0;
   bit   done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: floor((x + 2^14) / 2^15) in wide arithmetic, then clamp to 16 bits.
   function automatic logic [16:0] model(input logic [63:0] x);
      logic signed [127:0] t;
      t = 128'($signed(x));
      t = (t + 128'sd16384) >>> 15;
      if (t > 128'sd32767)  return {1'b1, 16'h7fff};
      if (t < -128'sd32768) return {1'b1, 16'h8000};
      return {1'b0, t[15:0]};
   endfunction

   function automatic logic [63:0] rnd64();
      logic signed [63:0] r;
      r = {$urandom(), $urandom()};
      r = r >>> $urandom_range(0, 48);
      return r;
   endfunction

   // Entered just after a rising edge; returns 1 ns after the accepting edge.
   task automatic send_block(input logic [63:0] a, b, c, input logic [15:0] e0, e1, e2);
      int w;
      in_phase0 = a;
      in_phase1 = b;
      in_phase2 = c;
      in_valid  = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         stall_cnt++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_wait", in_ready, 1);
      @(posedge clk);
      sb.push_back('{e0, 1'b0});
      sb.push_back('{e1, 1'b0});
      sb.push_back('{e2, 1'b1});
      #1 in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [63:0] a, b, c;
      logic [16:0] ma, mb, mc;
      a = rnd64(); b = rnd64(); c = rnd64();
      ma = model(a); mb = model(b); mc = model(c);
      send_block(a, b, c, ma[15:0], mb[15:0], mc[15:0]);
   endtask

   task automatic wait_drain(input int max);
      int c;
      c = 0;
      while (sb.size() != 0 && c < max) begin
         @(posedge clk);
         c++;
      end
      #1 chk("drain", sb.size(), 0);
   endtask

   // Sink-side monitor: scoreboard pop on every handshake, stability during stalls.
   initial begin
      logic [15:0] prev_d;
      bit          prev_stall;
      exp_t        e;
      prev_stall = 1'b0;
      prev_d     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_d);
            end
            if (gap_chk && !out_valid) gaps++;
            if (out_valid && out_ready) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL extra_sample: got %0h want none", out_data);
               end else begin
                  n_cmp--;
                  e = sb.pop_front();
                  chk("out_data", out_data, e.d);
                  chk("out_last", out_last, e.last);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
         end
      end
   end

   initial begin
      vec_t        tab[5];
      int          acc;
      int          base;
      bit          rdy;
      logic [63:0] a, b, c;
      logic [16:0] ma, mb, mc;

      tab[0] = '{64'd32768, 64'd98304, -64'sd16385, 16'd1, 16'd3, 16'hffff, 1'b0};
      tab[1] = '{64'h8000_0000, -64'sd2147483648, -64'sd16384, 16'h7fff, 16'h8000, 16'h0000, 1'b1};
      tab[2] = '{64'd0, 64'd16383, 64'd16384, 16'd0, 16'd0, 16'd1, 1'b0};
      tab[3] = '{-64'sd49153, 64'd1073709056, -64'sd1073758208, 16'hfffe, 16'h7fff, 16'h8000, 1'b0};
      tab[4] = '{64'd1073725440, -64'sd1073758209, 64'h7fff_ffff_ffff_ffff, 16'h7fff, 16'h8000, 16'h7fff, 1'b1};

      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sat_flag", sat_flag, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors: three samples on consecutive cycles, then sticky flag and clear
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_block(tab[i].p0, tab[i].p1, tab[i].p2, tab[i].e0, tab[i].e1, tab[i].e2);
         repeat (2) @(posedge clk);
         @(negedge clk); #1;
         chk("drain3", sb.size(), 0);
         chk("sat_flag", sat_flag, tab[i].s);
         @(posedge clk); #1 clr_sat = 1'b1;
         @(posedge clk); #1 clr_sat = 1'b0;
         chk("sat_clr", sat_flag, 0);
      end

      // Back-pressure: sink stalled, source keeps offering
      out_ready = 1'b0;
      acc = 0;
      a = rnd64(); b = rnd64(); c = rnd64();
      in_phase0 = a; in_phase1 = b; in_phase2 = c;
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            ma = model(a); mb = model(b); mc = model(c);
            sb.push_back('{ma[15:0], 1'b0});
            sb.push_back('{mb[15:0], 1'b0});
            sb.push_back('{mc[15:0], 1'b1});
            acc++;
            #1;
            a = rnd64(); b = rnd64(); c = rnd64();
            in_phase0 = a; in_phase1 = b; in_phase2 = c;
         end
      end
      #1 in_valid = 1'b0;
      chk("full_accepts", acc, 2);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("ready_after_pop", in_ready, (k == 2) ? 1 : 0);
      end
      wait_drain(20);

      // Sustained rate: one block every third cycle
      base = stall_cnt;
      gaps = 0;
      for (int n = 0; n < 100; n++) begin
         send_rand();
         if (n == 0) gap_chk = 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      gap_chk = 1'b0;
      chk("stream_stalls", stall_cnt - base, 0);
      chk("stream_gaps", gaps, 0);
      wait_drain(20);

      // Random sink back-pressure
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 20; n++) send_rand();
            done = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while ((!done || sb.size() != 0) && cyc < 3000) begin
               @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
               cyc++;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain(50);

      // Asynchronous reset mid-block (lane 1)
      out_ready = 1'b0;
      send_block(tab[0].p0, tab[0].p1, tab[0].p2, tab[0].e0, tab[0].e1, tab[0].e2);
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_last", out_last, 0);
      sb.delete();
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;
      send_block(tab[0].p0, tab[0].p1, tab[0].p2, tab[0].e0, tab[0].e1, tab[0].e2);
      wait_drain(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
